// File: rtl/clk_div_chk_pkg.sv
// Shared types and sizing rules for the divided-clock checker.
// The FSM state encoding and the counter-width rule live here so that other
// monitors built around the same measurement scheme stay consistent.
package clk_div_chk_pkg;

    // Run sequencing: wait for a start, align to the first rising edge,
    // measure NUM_PERIODS periods, then report for one cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // The cycle counter gets one bit more than the ratio width, so that it
    // can reach the timeout limit of 2^(DIV_W+1)-1.
    localparam int CNT_EXTRA_BITS = 1;

    function automatic int cnt_width(input int div_w);
        return div_w + CNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/clk_div_chk_sync.sv
// N-stage synchronizer with rising/falling edge detect on the synced level.
// The async input is treated as data; edges are one-cycle pulses in clk.
module clk_div_chk_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    assign sync_d = {sync_q[STAGES-2:0], async_i};

    // Shift the async input through the synchronizer and keep the previous synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clk_div_chk.sv
// Divided-clock checker: measures the period of a divided clock, sampled as
// data in the reference domain, over NUM_PERIODS consecutive periods and
// reports pass/fail against an expected divide ratio.
// Build option: define CLK_DIV_CHK_DUTY_EN to also require the high time of
// each period to equal exp_div>>1.
module clk_div_chk
    import clk_div_chk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int NUM_PERIODS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] exp_div,
    input  logic             divclk_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [DIV_W-1:0] meas_period,
    output logic [DIV_W-1:0] err_cnt
);

    localparam int CNT_W = cnt_width(DIV_W);
    localparam int PER_W = $clog2(NUM_PERIODS + 1);

    logic sync_level;
    logic sync_rise;
    logic sync_fall;

    clk_div_chk_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(divclk_in),
        .level_o(sync_level),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    // Only rising edges delimit periods; the level feeds the optional high-time count.
    logic unused_sync;
    assign unused_sync = &{1'b0, sync_fall, sync_level};

    state_e           state_q;
    logic [DIV_W-1:0] exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PER_W-1:0] per_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic [DIV_W-1:0] meas_q;
    logic [DIV_W-1:0] err_q;

    logic [CNT_W-1:0] cnt_d;
    logic             cnt_sat;
    logic             mismatch;
    logic [DIV_W-1:0] err_d;
    logic [DIV_W-1:0] meas_d;
    logic [PER_W-1:0] per_d;
    logic             per_last;

`ifdef CLK_DIV_CHK_DUTY_EN
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] hi_d;
    logic [CNT_W-1:0] exp_hi;

    // High-time counter: advances while the synced level is high, saturating.
    always_comb begin
        hi_d   = hi_q;
        exp_hi = {2'b00, exp_q[DIV_W-1:1]};
        if (sync_level && (hi_q != '1)) begin
            hi_d = hi_q + CNT_W'(1);
        end
    end
`endif

    // Next-value helpers for the cycle counter, error count and period bookkeeping.
    always_comb begin
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_sat  = (cnt_d == '1);
`ifdef CLK_DIV_CHK_DUTY_EN
        mismatch = (cnt_q != {1'b0, exp_q}) || (hi_q != exp_hi);
`else
        mismatch = (cnt_q != {1'b0, exp_q});
`endif
        err_d    = (mismatch && (err_q != '1)) ? err_q + DIV_W'(1) : err_q;
        // With CNT_W = DIV_W+1, the MSB alone says the count exceeds 2^DIV_W-1.
        meas_d   = cnt_q[CNT_W-1] ? '1 : cnt_q[DIV_W-1:0];
        per_d    = per_q + PER_W'(1);
        per_last = (per_d == PER_W'(NUM_PERIODS));
    end

    // Run-control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            meas_q    <= '0;
            err_q     <= '0;
`ifdef CLK_DIV_CHK_DUTY_EN
            hi_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        err_q     <= '0;
                        if (exp_div > DIV_W'(1)) begin
                            exp_q   <= exp_div;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ALIGN;
                        end else begin
                            // A ratio below 2 can never be a valid divider output.
                            done_q <= 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    if (sync_rise) begin
                        cnt_q   <= CNT_W'(1);
                        per_q   <= '0;
`ifdef CLK_DIV_CHK_DUTY_EN
                        hi_q    <= CNT_W'(1);
`endif
                        state_q <= MEASURE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_sat) begin
                            timeout_q <= 1'b1;
                            pass_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                MEASURE: begin
                    if (sync_rise) begin
                        meas_q <= meas_d;
                        err_q  <= err_d;
                        cnt_q  <= CNT_W'(1);
                        per_q  <= per_d;
`ifdef CLK_DIV_CHK_DUTY_EN
                        hi_q   <= CNT_W'(1);
`endif
                        if (per_last) begin
                            pass_q  <= (err_d == '0);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
`ifdef CLK_DIV_CHK_DUTY_EN
                        hi_q  <= hi_d;
`endif
                        if (cnt_sat) begin
                            timeout_q <= 1'b1;
                            pass_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign meas_period = meas_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_clk_div_chk.sv
// Bench for clk_div_chk: a generated divided clock with programmable period
// and high time, a scoreboard of expected run results, and cycle checks on
// done latency, busy and reset behaviour.
module tb_clk_div_chk;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] exp_div;
    logic       divclk_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] meas_period;
    logic [7:0] err_cnt;

    clk_div_chk #(
        .DIV_W      (8),
        .NUM_PERIODS(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .exp_div    (exp_div),
        .divclk_in  (divclk_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .meas_period(meas_period),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic       pass;
        logic       tmo;
        logic [7:0] meas;
        logic [7:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int div_per = 8;
    int div_hi  = 4;
    bit div_en  = 1'b0;
    int phase   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divided clock under test, updated away from the sampling edge.
    initial begin
        divclk_in = 1'b0;
        forever begin
            @(negedge clk);
            if (phase >= div_per - 1) phase = 0;
            else phase = phase + 1;
            divclk_in = div_en && (phase < div_hi);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [7:0] e);
        @(negedge clk);
        start   = 1'b1;
        exp_div = e;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic p, input logic t, input logic [7:0] m, input logic [7:0] e);
        exp_t x;
        x.pass = p;
        x.tmo  = t;
        x.meas = m;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // Starts at #1 after the edge that accepted start; lat counts edges since then.
    task automatic wait_done(input string tag, input int max_cyc, output int lat, output bit busy_seen);
        exp_t x;
        lat       = -1;
        busy_seen = 1'b0;
        for (int k = 0; k <= max_cyc; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            chk({tag, "_done_seen"}, 0, 1);
        end else if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            x = sb_q.pop_front();
            chk({tag, "_pass"}, pass, x.pass);
            chk({tag, "_timeout"}, timeout, x.tmo);
            chk({tag, "_meas"}, meas_period, x.meas);
            chk({tag, "_err"}, err_cnt, x.err);
            chk({tag, "_busy_at_done"}, busy, 0);
        end
    endtask

    initial begin
        int lat;
        bit bs;
        bit done_seen;

        rst     = 1'b1;
        start   = 1'b0;
        exp_div = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_meas", meas_period, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Matching ratio: clk/8, 50% duty.
        div_per = 8; div_hi = 4; div_en = 1'b1;
        repeat (10) @(posedge clk);
        kick(8'd8);
        push(1'b1, 1'b0, 8'd8, 8'd0);
        chk("t1_busy_after_start", busy, 1);
        wait_done("t1", 200, lat, bs);
        chk("t1_lat_range", (lat >= 33 && lat <= 44), 1);

        // Wrong expected ratio: every period mismatches.
        repeat (3) @(posedge clk);
        kick(8'd4);
        push(1'b0, 1'b0, 8'd8, 8'd4);
        wait_done("t2", 200, lat, bs);

        // Stuck-low divided clock: timeout after 511 cycles in ALIGN.
        div_en = 1'b0;
        repeat (10) @(posedge clk);
        kick(8'd8);
        push(1'b0, 1'b1, 8'd8, 8'd0);
        wait_done("t3", 600, lat, bs);
        chk("t3_lat", lat, 511);

        // Ignored second start, then reset mid-MEASURE.
        div_en = 1'b1;
        repeat (10) @(posedge clk);
        kick(8'd8);
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        kick(8'd4);
        repeat (16) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        chk("t4_busy_mid_run", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (done) done_seen = 1'b1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_meas", meas_period, 0);
        chk("t4_rst_err", err_cnt, 0);
        chk("t4_rst_pass", pass, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        chk("t4_no_done", done_seen, 0);
        chk("t4_idle_after_rst", busy, 0);
        kick(8'd8);
        push(1'b1, 1'b0, 8'd8, 8'd0);
        wait_done("t4b", 200, lat, bs);

        // Ratio below 2: immediate done, never busy.
        repeat (3) @(posedge clk);
        kick(8'd1);
        push(1'b0, 1'b0, 8'd8, 8'd0);
        wait_done("t5", 20, lat, bs);
        chk("t5_lat", lat, 0);
        chk("t5_busy_seen", bs, 0);

        // Period 8 with 3-cycle high time.
        div_hi = 3;
        repeat (10) @(posedge clk);
        kick(8'd8);
`ifdef CLK_DIV_CHK_DUTY_EN
        push(1'b0, 1'b0, 8'd8, 8'd4);
`else
        push(1'b1, 1'b0, 8'd8, 8'd0);
`endif
        wait_done("t6", 200, lat, bs);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_chk.md
Name: clk_div_chk

Overview:
- Measurement-side companion to the fixed power-of-2 clock divider; it checks the divider's output.
- Samples a divided clock as data in the reference clock domain.
- Measures its period, and optionally its high time, over NUM_PERIODS consecutive periods, then reports pass/fail against an expected divide ratio.
- Used in bring-up/DFT to prove divider outputs before the clock-mux select is released.

Parameters:
- DIV_W, 8: width of exp_div and meas_period; max expected ratio 2^DIV_W-1.
- NUM_PERIODS, 4: consecutive divclk periods checked per run (>=1).
- SYNC_STAGES, 2: synchronizer flop count on divclk_in (>=2).

Ports:
- clk  in  1  reference clock; the divider's refclk.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a run when idle.
- exp_div  in  DIV_W  expected period in clk cycles; sampled on accepted start.
- divclk_in  in  1  divided clock under test, treated as async data.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of last run; held until next accepted start.
- timeout  out  1  last run ended on timeout; held like pass.
- meas_period  out  DIV_W  period of the last measured divclk period, saturating.
- err_cnt  out  DIV_W  count of mismatching periods in the last run, saturating.

Behaviour:
- Clock and reset: single clock, clk; rst is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE. rst mid-run aborts with no done pulse.
- Synchronizer: divclk_in passes through SYNC_STAGES flops. Rise = sync & ~sync_d; fall likewise. The fixed latency cancels out of the period measurement.
- FSM IDLE:
  - start with exp_div>=2: latch exp_div, clear err_cnt/pass/timeout, go ALIGN, busy=1.
  - start with exp_div<2: done pulses next cycle with pass=0, timeout=0, err_cnt=0; stays IDLE.
- FSM ALIGN: wait for rise, then go MEASURE with cnt=1, hi=1, per=0.
- FSM MEASURE:
  - Each cycle cnt++ (saturating at 2^(DIV_W+1)-1). hi++ while the synced level is 1.
  - On rise: meas_period=min(cnt,2^DIV_W-1). Compare cnt==exp_div; mismatch increments err_cnt (saturating). Then cnt=1, hi=1, per++.
  - When per reaches NUM_PERIODS on that rise, go DONE.
- Timeout: if cnt saturates in ALIGN or MEASURE (no rise for 2^(DIV_W+1)-1 cycles), timeout=1, pass=0, go DONE.
- FSM DONE: one cycle. done=1, busy=0, pass=(err_cnt==0)&~timeout. Return to IDLE.
- start while busy is ignored. Only an idle start samples exp_div; later exp_div changes have no effect.
- done and a new start can never coincide, because start is only accepted from IDLE.

Optional Feature:
- Macro: CLK_DIV_CHK_DUTY_EN.
- Defined: each period also requires hi==exp_div>>1. Failing either the period check or the high-time check counts as one mismatch.
- Undefined: no hi counter is synthesized; only the period is checked.

Decomposition:
- Package clk_div_chk_pkg holds:
  - FSM state enum: IDLE, ALIGN, MEASURE, DONE.
  - Counter-width localparam rule: CNT_W=DIV_W+1.
- One sub-module: clk_div_chk_sync, an N-stage synchronizer plus rise/fall edge detect, reusable by other monitors.

Test Plan:
- Bench divclk=clk/8, 50% duty; start, exp_div=8 -> done after ALIGN + 4 periods; pass=1, meas_period=8, err_cnt=0, timeout=0.
- Bench clk/8; exp_div=4 -> pass=0, err_cnt=4, meas_period=8.
- divclk_in held 0; exp_div=8, DIV_W=8 -> done 511 cycles after start is accepted; timeout=1, pass=0.
- Second start while busy, then rst asserted mid-MEASURE -> no done pulse; outputs 0; FSM in IDLE; a new run passes normally.
- exp_div=1 -> done one cycle after start; pass=0, busy never asserted.
- divclk period 8, high 3 cycles; exp_div=8 -> DUTY_EN defined: pass=0, err_cnt=4; undefined: pass=1.
